// File: rtl/vs_ram_burst_reader.sv
// ============================================================================
// Module   : vs_ram_burst_reader
// Purpose  : Walks a contiguous RAM address range and streams the returned
//            words out as valid/ready/last, behind a 2-entry skid buffer.
// Options  : VS_RAM_READER_ABORT_EN adds abort input and aborted pulse output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vs_ram_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef VS_RAM_READER_ABORT_EN
    ,
    input  logic                  abort,
    output logic                  aborted
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0] c_one     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_max_len = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic                    r_inflight;
    logic                    r_inflight_last;
    logic [DATA_WIDTH-1:0]   r_buf_data [2];
    logic                    r_buf_last [2];
    logic                    r_rd_ptr;
    logic                    r_wr_ptr;
    logic [1:0]              r_count;
    logic                    r_done;
    logic                    r_aborted;
    logic                    w_pop;
    logic                    w_issue;
    logic                    w_finish;
    logic                    w_abort;
    logic                    w_room;
    logic [ADDR_WIDTH:0]     w_len_clamped;

`ifdef VS_RAM_READER_ABORT_EN
    assign w_abort = abort && (r_state == ST_RUN);
    assign aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    assign out_valid     = (r_count != 2'd0);
    assign out_data      = r_buf_data[r_rd_ptr];
    assign out_last      = out_valid && r_buf_last[r_rd_ptr];
    assign busy          = (r_state == ST_RUN);
    assign done          = r_done;
    assign ram_read_addr = r_addr;
    assign w_pop         = out_valid && out_ready;
    assign w_len_clamped = length[ADDR_WIDTH] ? c_max_len : length;

    // Count the in-flight word as already occupying a slot so it can never overflow.
    assign w_room = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (length != '0)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_issue = (r_remaining != '0) && w_room;
                    if (w_pop && out_last) begin
                        w_state_next = ST_IDLE;
                        w_finish     = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_buf_data      <= '{default: '0};
            r_buf_last      <= '{default: 1'b0};
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_done          <= 1'b0;
            r_aborted       <= 1'b0;
        end else begin
            r_done    <= w_finish;
            r_aborted <= 1'b0;
            if ((r_state == ST_IDLE) && start) begin
                if (length == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_addr      <= base_addr;
                    r_remaining <= w_len_clamped;
                end
            end
            if (w_abort) begin
                r_inflight      <= 1'b0;
                r_inflight_last <= 1'b0;
                r_remaining     <= '0;
                r_count         <= 2'd0;
                r_rd_ptr        <= 1'b0;
                r_wr_ptr        <= 1'b0;
                r_aborted       <= 1'b1;
            end else begin
                r_inflight      <= w_issue;
                r_inflight_last <= w_issue && (r_remaining == c_one);
                if (w_issue) begin
                    r_addr      <= r_addr + 1'b1;
                    r_remaining <= r_remaining - c_one;
                end
                // The RAM output register holds the word addressed one edge earlier.
                if (r_inflight) begin
                    r_buf_data[r_wr_ptr] <= ram_out_data;
                    r_buf_last[r_wr_ptr] <= r_inflight_last;
                    r_wr_ptr             <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vs_ram_burst_reader.sv
// ============================================================================
// Module   : tb_vs_ram_burst_reader
// Purpose  : Directed self-checking bench for vs_ram_burst_reader with a
//            1-cycle registered RAM model holding ram[i] = i & 0xFF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vs_ram_burst_reader;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 16;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] base_addr = '0;
    logic [ADDR_WIDTH:0]   length = '0;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_read_addr;
    logic [DATA_WIDTH-1:0] ram_out_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
`ifdef VS_RAM_READER_ABORT_EN
    logic                  abort = 1'b0;
    logic                  aborted;
`endif

    int errors = 0;
    int checks = 0;

    vs_ram_burst_reader #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_read_addr(ram_read_addr),
        .ram_out_data (ram_out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
`ifdef VS_RAM_READER_ABORT_EN
        ,
        .abort        (abort),
        .aborted      (aborted)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) ram_out_data <= ram_read_addr[7:0];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in cycle c1 (one cycle after start was sampled).
    task automatic start_burst(input logic [ADDR_WIDTH-1:0] b, input logic [ADDR_WIDTH:0] n);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Collects n words under optional 1,0,0,1 backpressure and checks order, last, stall hold, done.
    task automatic stream_check(input string tag, input logic [7:0] b, input int n, input bit toggle);
        int          got;
        int          cyc;
        logic [3:0]  pat;
        logic [7:0]  prev_data;
        bit          prev_stall;
        got        = 0;
        cyc        = 0;
        pat        = 4'b1001;
        prev_data  = '0;
        prev_stall = 1'b0;
        while ((got < n) && (cyc < 200)) begin
            out_ready = toggle ? pat[cyc % 4] : 1'b1;
            if (prev_stall) begin
                check({tag, " stall valid"}, {31'd0, out_valid}, 32'd1);
                check({tag, " stall data"}, {24'd0, out_data}, {24'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                check({tag, " data"}, {24'd0, out_data}, {24'd0, b + 8'(got)});
                check({tag, " last"}, {31'd0, out_last}, {31'd0, (got == n - 1)});
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, " word count"}, got, n);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " valid after"}, {31'd0, out_valid}, 32'd0);
        check({tag, " busy after"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, " done clear"}, {31'd0, done}, 32'd0);
        check({tag, " no stray word"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst valid", {31'd0, out_valid}, 32'd0);
        check("rst last", {31'd0, out_last}, 32'd0);
        check("rst addr", {16'd0, ram_read_addr}, 32'd0);
        check("rst data", {24'd0, out_data}, 32'd0);

        // Burst base 0x10 length 4 at full throughput
        start_burst(16'h0010, 17'd4);
        check("b1 c1 busy", {31'd0, busy}, 32'd1);
        check("b1 c1 addr", {16'd0, ram_read_addr}, 32'h10);
        check("b1 c1 valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("b1 c2 valid", {31'd0, out_valid}, 32'd0);
        check("b1 c2 addr", {16'd0, ram_read_addr}, 32'h11);
        tick();
        check("b1 c3 valid", {31'd0, out_valid}, 32'd1);
        check("b1 c3 data", {24'd0, out_data}, 32'h10);
        check("b1 c3 last", {31'd0, out_last}, 32'd0);
        tick();
        check("b1 c4 data", {24'd0, out_data}, 32'h11);
        tick();
        check("b1 c5 data", {24'd0, out_data}, 32'h12);
        check("b1 c5 last", {31'd0, out_last}, 32'd0);
        tick();
        check("b1 c6 data", {24'd0, out_data}, 32'h13);
        check("b1 c6 last", {31'd0, out_last}, 32'd1);
        check("b1 c6 busy", {31'd0, busy}, 32'd1);
        check("b1 c6 done", {31'd0, done}, 32'd0);
        tick();
        check("b1 c7 valid", {31'd0, out_valid}, 32'd0);
        check("b1 c7 busy", {31'd0, busy}, 32'd0);
        check("b1 c7 done", {31'd0, done}, 32'd1);
        tick();
        check("b1 c8 done", {31'd0, done}, 32'd0);

        // Address wrap from 0xFFFE
        start_burst(16'hFFFE, 17'd4);
        check("wrap c1 addr", {16'd0, ram_read_addr}, 32'hFFFE);
        tick();
        check("wrap c2 addr", {16'd0, ram_read_addr}, 32'hFFFF);
        tick();
        check("wrap c3 addr", {16'd0, ram_read_addr}, 32'h0000);
        check("wrap c3 data", {24'd0, out_data}, 32'hFE);
        tick();
        check("wrap c4 addr", {16'd0, ram_read_addr}, 32'h0001);
        check("wrap c4 data", {24'd0, out_data}, 32'hFF);
        tick();
        check("wrap c5 data", {24'd0, out_data}, 32'h00);
        check("wrap c5 addr", {16'd0, ram_read_addr}, 32'h0002);
        tick();
        check("wrap c6 data", {24'd0, out_data}, 32'h01);
        check("wrap c6 last", {31'd0, out_last}, 32'd1);
        tick();
        check("wrap c7 done", {31'd0, done}, 32'd1);
        tick();

        // Length 8 with 1,0,0,1 backpressure
        start_burst(16'h0020, 17'd8);
        stream_check("bp", 8'h20, 8, 1'b1);

        // Zero-length command
        start_burst(16'h0030, 17'd0);
        check("zero done", {31'd0, done}, 32'd1);
        check("zero busy", {31'd0, busy}, 32'd0);
        check("zero valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("zero done clear", {31'd0, done}, 32'd0);
        check("zero valid2", {31'd0, out_valid}, 32'd0);

        // Reset after 3 of 8 words
        start_burst(16'h0040, 17'd8);
        tick();
        tick();
        check("mid c3 data", {24'd0, out_data}, 32'h40);
        tick();
        tick();
        check("mid c5 data", {24'd0, out_data}, 32'h42);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst done", {31'd0, done}, 32'd0);
        check("mid rst valid", {31'd0, out_valid}, 32'd0);
        check("mid rst last", {31'd0, out_last}, 32'd0);
        check("mid rst addr", {16'd0, ram_read_addr}, 32'd0);
        check("mid rst data", {24'd0, out_data}, 32'd0);
        tick();
        check("mid post valid", {31'd0, out_valid}, 32'd0);
        check("mid post done", {31'd0, done}, 32'd0);
        start_burst(16'h0000, 17'd2);
        stream_check("post", 8'h00, 2, 1'b0);

`ifdef VS_RAM_READER_ABORT_EN
        // Abort after 2 of 6 words
        start_burst(16'h0050, 17'd6);
        tick();
        tick();
        check("ab c3 data", {24'd0, out_data}, 32'h50);
        tick();
        check("ab c4 data", {24'd0, out_data}, 32'h51);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab valid", {31'd0, out_valid}, 32'd0);
        check("ab aborted", {31'd0, aborted}, 32'd1);
        check("ab done", {31'd0, done}, 32'd0);
        check("ab busy", {31'd0, busy}, 32'd0);
        tick();
        check("ab aborted clear", {31'd0, aborted}, 32'd0);
        check("ab done2", {31'd0, done}, 32'd0);
        check("ab valid2", {31'd0, out_valid}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
